// File: rtl/traffic_monitor.sv
// traffic_monitor: checks a 4-way signal controller for sequence and conflict faults.
// Optional MON_TRANSITION_CHECK_EN adds the per-approach transition check (code 5).
module traffic_monitor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] n_car,
    input  logic [1:0] s_car,
    input  logic [1:0] e_car,
    input  logic [1:0] w_car,
    input  logic [1:0] n_ped,
    input  logic [1:0] s_ped,
    input  logic [1:0] e_ped,
    input  logic [1:0] w_ped,
    input  logic [6:0] i_cycle,
    input  logic       i_clear,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic [6:0] o_fault_cycle,
    output logic [7:0] o_period_cnt,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;
    localparam logic [1:0] LEFT   = 2'b11;
    localparam logic [6:0] CYC_FIRST = 7'd1;
    localparam logic [6:0] CYC_LAST  = 7'd68;

    state_t     state_q;
    state_t     state_d;
    logic [6:0] prev_cycle_q;
    logic [2:0] code;
    logic       in_range;
    logic       seq_ok;
    logic       wrap;
    logic       flt_seq;
    logic       flt_axis;
    logic       flt_car;
    logic       flt_ped;
    logic       flt_trans;
    logic       load_prev;
    logic       latch_fault;
    logic       clr_fault;
    logic       cnt_inc;

    assign in_range = (i_cycle >= CYC_FIRST) && (i_cycle <= CYC_LAST);
    assign wrap     = (prev_cycle_q == CYC_LAST) && (i_cycle == CYC_FIRST);
    assign seq_ok   = in_range
                    && (wrap
                        || ((prev_cycle_q >= CYC_FIRST)
                            && (prev_cycle_q < CYC_LAST)
                            && (i_cycle == prev_cycle_q + 7'd1)));
    assign flt_seq  = !seq_ok;
    assign flt_axis = (n_car != s_car) || (n_ped != s_ped)
                    || (e_car != w_car) || (e_ped != w_ped);
    assign flt_car  = (n_car != RED) && (e_car != RED);
    assign flt_ped  = ((n_ped != RED) && (n_car != RED))
                    || ((s_ped != RED) && (s_car != RED))
                    || ((e_ped != RED) && (e_car != RED))
                    || ((w_ped != RED) && (w_car != RED))
                    || (n_ped == 2'b11) || (s_ped == 2'b11)
                    || (e_ped == 2'b11) || (w_ped == 2'b11);

`ifdef MON_TRANSITION_CHECK_EN
    logic [7:0] prev_car_q;
    logic [7:0] cur_car;

    assign cur_car = {n_car, s_car, e_car, w_car};

    // Illegal steps: GREEN straight to RED, LEFT to anything but LEFT/YELLOW
    always_comb begin
        flt_trans = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((prev_car_q[2*i +: 2] == GREEN)
                && (cur_car[2*i +: 2] == RED))
                flt_trans = 1'b1;
            if ((prev_car_q[2*i +: 2] == LEFT)
                && (cur_car[2*i +: 2] != LEFT)
                && (cur_car[2*i +: 2] != YELLOW))
                flt_trans = 1'b1;
        end
    end

    // Car history only feeds the transition check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev_car_q <= '0;
        else if (load_prev)
            prev_car_q <= cur_car;
    end
`else
    assign flt_trans = 1'b0;
`endif

    // Lowest fault code wins when several fire together
    always_comb begin
        code = 3'd0;
        if (flt_seq)
            code = 3'd1;
        else if (flt_axis)
            code = 3'd2;
        else if (flt_car)
            code = 3'd3;
        else if (flt_ped)
            code = 3'd4;
        else if (flt_trans)
            code = 3'd5;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_SYNC;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SYNC:  if (i_cycle == CYC_FIRST) state_d = ST_RUN;
            ST_RUN:   if (code != 3'd0) state_d = ST_FAULT;
            ST_FAULT: if (i_clear) state_d = ST_SYNC;
            default:  state_d = ST_SYNC;
        endcase
    end

    // Output / control decode from the current state
    always_comb begin
        o_state     = state_q;
        load_prev   = 1'b0;
        latch_fault = 1'b0;
        clr_fault   = 1'b0;
        cnt_inc     = 1'b0;
        unique case (state_q)
            ST_SYNC: load_prev = (i_cycle == CYC_FIRST);
            ST_RUN: begin
                load_prev   = 1'b1;
                latch_fault = (code != 3'd0);
                cnt_inc     = (code == 3'd0) && wrap;
            end
            ST_FAULT: clr_fault = i_clear;
            default: ;
        endcase
    end

    // Previous cycle index for the sequence check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev_cycle_q <= '0;
        else if (load_prev)
            prev_cycle_q <= i_cycle;
    end

    // Sticky first-fault record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fault       <= 1'b0;
            o_fault_code  <= '0;
            o_fault_cycle <= '0;
        end else if (latch_fault) begin
            o_fault       <= 1'b1;
            o_fault_code  <= code;
            o_fault_cycle <= i_cycle;
        end else if (clr_fault) begin
            o_fault       <= 1'b0;
            o_fault_code  <= '0;
            o_fault_cycle <= '0;
        end
    end

    // Completed-period counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_period_cnt <= '0;
        else if (cnt_inc)
            o_period_cnt <= o_period_cnt + 8'd1;
    end

endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: vector table, directed corner sequences and random
// stimulus against a rule-level reference model of traffic_monitor.
module tb_traffic_monitor;

    localparam int S_SYNC  = 0;
    localparam int S_RUN   = 1;
    localparam int S_FAULT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] n_car = '0, s_car = '0, e_car = '0, w_car = '0;
    logic [1:0] n_ped = '0, s_ped = '0, e_ped = '0, w_ped = '0;
    logic [6:0] i_cycle = '0;
    logic       i_clear = 1'b0;
    logic       o_fault;
    logic [2:0] o_fault_code;
    logic [6:0] o_fault_cycle;
    logic [7:0] o_period_cnt;
    logic [1:0] o_state;

    int checks = 0;
    int failures = 0;

    int m_st, m_pcyc, m_fault, m_code, m_fcyc, m_cnt;
    int m_pcar[4];
    int cur_car[4];
    int cur_ped[4];

    typedef struct {
        int         at;
        int         cyc;
        logic [7:0] car;
        logic [7:0] ped;
        int         code;
    } vec_t;

    vec_t vecs[9];

    traffic_monitor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .n_car         (n_car),
        .s_car         (s_car),
        .e_car         (e_car),
        .w_car         (w_car),
        .n_ped         (n_ped),
        .s_ped         (s_ped),
        .e_ped         (e_ped),
        .w_ped         (w_ped),
        .i_cycle       (i_cycle),
        .i_clear       (i_clear),
        .o_fault       (o_fault),
        .o_fault_code  (o_fault_code),
        .o_fault_cycle (o_fault_cycle),
        .o_period_cnt  (o_period_cnt),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Legal controller plan: {n,s,e,w} car and ped codes for a cycle index
    function automatic logic [7:0] pat_car(int c);
        logic [1:0] ns, ew;
        ns = 2'b00;
        ew = 2'b00;
        if (c >= 1 && c <= 20) ns = 2'b01;
        else if (c >= 21 && c <= 24) ns = 2'b10;
        if (c >= 29 && c <= 34) ew = 2'b11;
        else if (c >= 35 && c <= 36) ew = 2'b10;
        else if (c >= 39 && c <= 52) ew = 2'b01;
        else if (c >= 53 && c <= 56) ew = 2'b10;
        return {ns, ns, ew, ew};
    endfunction

    function automatic logic [7:0] pat_ped(int c);
        logic [1:0] ns, ew;
        ns = 2'b00;
        ew = 2'b00;
        if (c >= 29 && c <= 48) ns = 2'b01;
        else if (c >= 49 && c <= 52) ns = 2'b10;
        if (c >= 1 && c <= 20) ew = 2'b01;
        else if (c >= 21 && c <= 24) ew = 2'b10;
        return {ns, ns, ew, ew};
    endfunction

    // Fault code the rules demand for the current inputs
    function automatic int exp_code(int cyc);
        bit ok;
        ok = (cyc >= 1 && cyc <= 68)
           && ((m_pcyc >= 1 && m_pcyc <= 67 && cyc == m_pcyc + 1)
               || (m_pcyc == 68 && cyc == 1));
        if (!ok) return 1;
        if (cur_car[0] != cur_car[1] || cur_ped[0] != cur_ped[1]
            || cur_car[2] != cur_car[3] || cur_ped[2] != cur_ped[3])
            return 2;
        if (cur_car[0] != 0 && cur_car[2] != 0) return 3;
        for (int i = 0; i < 4; i++)
            if ((cur_ped[i] != 0 && cur_car[i] != 0) || cur_ped[i] == 3)
                return 4;
`ifdef MON_TRANSITION_CHECK_EN
        for (int i = 0; i < 4; i++)
            if ((m_pcar[i] == 1 && cur_car[i] == 0)
                || (m_pcar[i] == 3 && cur_car[i] != 3 && cur_car[i] != 2))
                return 5;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_st = S_SYNC;
        m_pcyc = 0;
        m_fault = 0;
        m_code = 0;
        m_fcyc = 0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_pcar[i] = 0;
    endtask

    task automatic model_step(int cyc, bit clr);
        int c;
        case (m_st)
            S_SYNC: if (cyc == 1) begin
                m_st = S_RUN;
                m_pcyc = cyc;
                m_pcar = cur_car;
            end
            S_RUN: begin
                c = exp_code(cyc);
                if (c != 0) begin
                    m_fault = 1;
                    m_code = c;
                    m_fcyc = cyc;
                    m_st = S_FAULT;
                end else if (m_pcyc == 68 && cyc == 1) begin
                    m_cnt = (m_cnt + 1) % 256;
                end
                m_pcyc = cyc;
                m_pcar = cur_car;
            end
            default: if (clr) begin
                m_fault = 0;
                m_code = 0;
                m_fcyc = 0;
                m_st = S_SYNC;
            end
        endcase
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("o_fault", int'(o_fault), m_fault);
        chk("o_fault_code", int'(o_fault_code), m_code);
        chk("o_fault_cycle", int'(o_fault_cycle), m_fcyc);
        chk("o_period_cnt", int'(o_period_cnt), m_cnt);
        chk("o_state", int'(o_state), m_st);
    endtask

    task automatic apply(int cyc, logic [7:0] car, logic [7:0] ped, bit clr);
        logic [6:0] cv;
        cv = 7'(cyc);
        i_cycle = cv;
        i_clear = clr;
        {n_car, s_car, e_car, w_car} = car;
        {n_ped, s_ped, e_ped, w_ped} = ped;
        cur_car[0] = n_car; cur_car[1] = s_car;
        cur_car[2] = e_car; cur_car[3] = w_car;
        cur_ped[0] = n_ped; cur_ped[1] = s_ped;
        cur_ped[2] = e_ped; cur_ped[3] = w_ped;
        model_step(int'(cv), clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic legal(int c);
        apply(c, pat_car(c), pat_ped(c), 1'b0);
    endtask

    task automatic run_to(int from, int to);
        for (int c = from; c <= to; c++) legal(c);
    endtask

    // Reset asserted between edges; outputs must clear before any clock
    task automatic do_reset();
        i_clear = 1'b0;
        i_cycle = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{at: 11, cyc: 12, car: 8'h50, ped: 8'h05, code: 1};
        vecs[1] = '{at: 20, cyc: 20, car: 8'h4A, ped: 8'h00, code: 2};
        vecs[2] = '{at: 20, cyc: 20, car: 8'h5A, ped: 8'h00, code: 3};
        vecs[3] = '{at: 10, cyc: 10, car: 8'h50, ped: 8'h50, code: 4};
        vecs[4] = '{at: 10, cyc: 10, car: 8'h50, ped: 8'h0F, code: 4};
        vecs[5] = '{at: 68, cyc: 69, car: 8'h00, ped: 8'h00, code: 1};
        vecs[6] = '{at: 5,  cyc: 0,  car: 8'h50, ped: 8'h05, code: 1};
        vecs[7] = '{at: 15, cyc: 17, car: 8'h40, ped: 8'h05, code: 1};
        vecs[8] = '{at: 30, cyc: 30, car: 8'h0F, ped: 8'h55, code: 4};

        #1;
        do_reset();

        // Start mid-period: no checking until cycle 1 is seen
        run_to(5, 68);
        chk("sync_hold_state", int'(o_state), S_SYNC);
        legal(1);
        chk("sync_enter_state", int'(o_state), S_RUN);
        chk("sync_enter_fault", int'(o_fault), 0);

        // Three full legal periods
        run_to(2, 68);
        run_to(1, 68);
        run_to(1, 68);
        legal(1);
        chk("three_periods_cnt", int'(o_period_cnt), 3);
        chk("three_periods_fault", int'(o_fault), 0);

        // Cycle skip 10 -> 12, later faults ignored
        run_to(2, 10);
        apply(12, pat_car(12), pat_ped(12), 1'b0);
        chk("skip_fault", int'(o_fault), 1);
        chk("skip_code", int'(o_fault_code), 1);
        chk("skip_cycle", int'(o_fault_cycle), 12);
        chk("skip_state", int'(o_state), S_FAULT);
        apply(0, 8'hFF, 8'hFF, 1'b0);
        chk("fault_hold_code", int'(o_fault_code), 1);
        chk("fault_hold_cycle", int'(o_fault_cycle), 12);

        // Acknowledge, then clear in RUN is inert, then async reset
        apply(5, pat_car(5), pat_ped(5), 1'b1);
        chk("clear_fault", int'(o_fault), 0);
        chk("clear_code", int'(o_fault_code), 0);
        chk("clear_cycle", int'(o_fault_cycle), 0);
        chk("clear_state", int'(o_state), S_SYNC);
        chk("clear_cnt_kept", int'(o_period_cnt), 3);
        legal(1);
        run_to(2, 30);
        apply(31, pat_car(31), pat_ped(31), 1'b1);
        chk("clear_in_run_state", int'(o_state), S_RUN);
        do_reset();
        chk("async_rst_cnt", int'(o_period_cnt), 0);
        chk("async_rst_state", int'(o_state), S_SYNC);

        // Vector table: single injected edge after a legal run-up
        for (int k = 0; k < 9; k++) begin
            do_reset();
            run_to(1, vecs[k].at - 1);
            apply(vecs[k].cyc, vecs[k].car, vecs[k].ped, 1'b0);
            chk($sformatf("vec%0d_fault", k), int'(o_fault), 1);
            chk($sformatf("vec%0d_code", k), int'(o_fault_code), vecs[k].code);
            chk($sformatf("vec%0d_cycle", k), int'(o_fault_cycle), vecs[k].cyc);
            chk($sformatf("vec%0d_state", k), int'(o_state), S_FAULT);
        end

        // Fault on the wrap edge suppresses the count
        do_reset();
        run_to(1, 68);
        apply(1, 8'h40, 8'h05, 1'b0);
        chk("wrap_fault_code", int'(o_fault_code), 2);
        chk("wrap_fault_cnt", int'(o_period_cnt), 0);

        // North/south GREEN -> RED at cycle 40
        do_reset();
        run_to(1, 38);
        apply(39, 8'h50, 8'h00, 1'b0);
        apply(40, 8'h00, 8'h00, 1'b0);
`ifdef MON_TRANSITION_CHECK_EN
        chk("trans_code", int'(o_fault_code), 5);
        chk("trans_cycle", int'(o_fault_cycle), 40);
`else
        chk("trans_off_fault", int'(o_fault), 0);
        chk("trans_off_state", int'(o_state), S_RUN);
`endif

        // Counter wraps 255 -> 0
        do_reset();
        legal(1);
        for (int p = 0; p < 256; p++) begin
            run_to(2, 68);
            legal(1);
            if (p == 254)
                chk("cnt_255", int'(o_period_cnt), 255);
        end
        chk("cnt_wrap_0", int'(o_period_cnt), 0);

        // Random legal traffic with sparse corruption, clears and resets
        begin
            int c;
            int r;
            c = $urandom_range(1, 68);
            for (int n = 0; n < 4000; n++) begin
                r = $urandom_range(0, 199);
                if (r == 0)
                    do_reset();
                else if (r < 3)
                    apply($urandom_range(0, 127), pat_car(c), pat_ped(c),
                          $urandom_range(0, 7) == 0);
                else if (r < 6)
                    apply(c, 8'($urandom), 8'($urandom),
                          $urandom_range(0, 7) == 0);
                else
                    apply(c, pat_car(c), pat_ped(c),
                          $urandom_range(0, 15) == 0);
                c = (c == 68) ? 1 : c + 1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the ports n_car, s_car, e_car, w_car, input, 2 bits each: car signal per approach (00 RED, 01 GREEN, 10 YELLOW, 11 LEFT).
REQ-004 The block SHALL have the ports n_ped, s_ped, e_ped, w_ped, input, 2 bits each: pedestrian signal per approach (00 RED, 01 GREEN, 10 BLINK, 11 illegal).
REQ-005 The block SHALL have the port i_cycle, input, 7 bits: the controller's cycle index, legal range 1..68.
REQ-006 The block SHALL have the port i_clear, input, 1 bit: fault acknowledge.
REQ-007 The block SHALL have the port o_fault, output, 1 bit: sticky fault flag.
REQ-008 The block SHALL have the port o_fault_code, output, 3 bits: first fault detected (0 = none).
REQ-009 The block SHALL have the port o_fault_cycle, output, 7 bits: i_cycle value at the first fault.
REQ-010 The block SHALL have the port o_period_cnt, output, 8 bits: number of completed 68-cycle periods.
REQ-011 The block SHALL have the port o_state, output, 2 bits: FSM state (00 SYNC, 01 RUN, 10 FAULT).

Function
REQ-012 The FSM SHALL have three states: SYNC (no checking), RUN (checking), and FAULT (latched).
REQ-013 In SYNC, sampling i_cycle==1 SHALL move the FSM to RUN and load the previous-sample registers (cycle, four car, four ped); the checks SHALL NOT run on that edge.
REQ-014 In RUN, every edge SHALL evaluate the current inputs against the previous-sample registers, then reload those registers.
REQ-015 Fault code 1 (sequence) SHALL be raised when i_cycle is neither prev+1 (prev 1..67) nor 1 after prev 68, or when i_cycle is outside 1..68.
REQ-016 Fault code 2 (axis mismatch) SHALL be raised when n_car!=s_car, n_ped!=s_ped, e_car!=w_car, or e_ped!=w_ped.
REQ-017 Fault code 3 (car conflict) SHALL be raised when n_car!=RED and e_car!=RED.
REQ-018 Fault code 4 (ped conflict) SHALL be raised when, on the same axis, ped!=RED and car!=RED, or when any ped input equals 11.
REQ-019 Fault code 5 (transition) SHALL be raised on any approach that goes GREEN->RED directly, or LEFT->anything other than LEFT or YELLOW (only when MON_TRANSITION_CHECK_EN is defined).
REQ-020 When several faults occur on the same edge, the lowest code SHALL win.
REQ-021 On detecting a fault, the block SHALL, on that same edge, set o_fault=1, latch o_fault_code and o_fault_cycle=i_cycle, and move the FSM to FAULT (zero added latency).
REQ-022 In FAULT, no checks SHALL run and the latched outputs SHALL hold; later faults SHALL be ignored.
REQ-023 In FAULT, i_clear=1 SHALL clear o_fault, o_fault_code and o_fault_cycle to 0 and return the FSM to SYNC; i_clear SHALL have no effect in SYNC or RUN.
REQ-024 In RUN, o_period_cnt SHALL increment on each legal 68->1 wrap and wrap 255->0.
REQ-025 o_period_cnt SHALL be preserved across FAULT and i_clear.
REQ-026 A fault occurring on the wrap edge SHALL suppress the increment.

Reset
REQ-027 rst_n low SHALL immediately force: FSM to SYNC, o_fault=0, o_fault_code=0, o_fault_cycle=0, o_period_cnt=0, and all previous-sample registers to 0, independent of clk.
REQ-028 Reset asserted mid-period SHALL abandon the period without counting it; after release, checking SHALL resume only at the next i_cycle==1.

Configuration
REQ-029 The macro MON_TRANSITION_CHECK_EN SHALL control the transition check: when defined, fault code 5 is checked; when undefined, the transition logic is absent, code 5 never appears, and all other behaviour is identical.

Verification
REQ-030 The bench SHALL cover: release reset with i_cycle=5 and counting upward -> o_state stays SYNC until i_cycle=1 is sampled, then RUN, with o_fault=0.
REQ-031 The bench SHALL cover: a legal controller running 3 full periods (1..68 x3, then 1) -> o_period_cnt=3 and o_fault=0.
REQ-032 The bench SHALL cover: i_cycle jumping 10->12 -> o_fault=1, o_fault_code=1, o_fault_cycle=12, and o_state=FAULT on that edge.
REQ-033 The bench SHALL cover: at cycle 20, n_car=GREEN and e_car=YELLOW with s_car!=n_car also injected -> o_fault_code=2 (priority over code 3).
REQ-034 The bench SHALL cover: with MON_TRANSITION_CHECK_EN defined, n_car/s_car going GREEN->RED at cycle 40 -> o_fault_code=5 and o_fault_cycle=40; with the macro undefined, the same stimulus -> o_fault=0.
REQ-035 The bench SHALL cover: in FAULT, pulse i_clear -> fault outputs=0, o_state=SYNC, o_period_cnt unchanged; then assert rst_n=0 mid-period -> all outputs 0 asynchronously.
